// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Per-channel automatic clock gating: RUN -> GATED after a run of idle cycles,
// GATED -> WAKE on activity, WAKE -> RUN once the clock has settled.
//
// state | meaning
// RUN   | clock running; counting consecutive idle cycles toward gating
// GATED | clock stopped; waiting for busy, force or wake activity
// WAKE  | clock restarted; counting settle cycles before acknowledging
module cv32e40p_clock_gate_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scan_cg_en_i,
    input  logic [NUM_CH-1:0] force_on_i,
    input  logic [NUM_CH-1:0] busy_i,
    input  logic [NUM_CH-1:0] wake_req_i,
    output logic [NUM_CH-1:0] wake_ack_o,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] gated_o,
    output logic              all_gated_o,
    output logic [NUM_CH-1:0] clk_o
);

    localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic             AUTO_GATE = (IDLE_CYCLES != 0);
    localparam logic [CNT_W-1:0] IDLE_TC   = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] IDLE_SAT  = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_TC   = CNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    state_t           r_state     [NUM_CH];
    state_t           w_state_nxt [NUM_CH];
    logic [CNT_W-1:0] r_cnt       [NUM_CH];
    logic [CNT_W-1:0] w_cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] r_clk_en;
    logic [NUM_CH-1:0] r_gated;
    logic [NUM_CH-1:0] w_act;
    logic [NUM_CH-1:0] w_wake_ack;

    assign w_act = busy_i | force_on_i | wake_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_RUN;
                r_cnt[i]   <= '0;
            end
            r_clk_en <= '1;
            r_gated  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
                r_clk_en[i] <= (w_state_nxt[i] != ST_GATED);
                r_gated[i]  <= (w_state_nxt[i] == ST_GATED);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_RUN: begin
                    if (w_act[i]) begin
                        w_cnt_nxt[i] = '0;
                    end else if (AUTO_GATE && (r_cnt[i] == IDLE_TC)) begin
                        w_state_nxt[i] = ST_GATED;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] < IDLE_SAT) begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                ST_GATED: begin
                    if (w_act[i]) begin
                        w_state_nxt[i] = ST_WAKE;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_WAKE: begin
                    // Dropping activity here does not abort; the settle count always completes.
                    if (r_cnt[i] == WAKE_TC) begin
                        w_state_nxt[i] = ST_RUN;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_RUN;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Ack is suppressed while reset is held so a pending request is not acked mid-reset.
    always_comb begin
        w_wake_ack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wake_ack[i] = (r_state[i] == ST_RUN) & wake_req_i[i] & ~rst_i;
        end
    end

    assign wake_ack_o  = w_wake_ack;
    assign clk_en_o    = r_clk_en;
    assign gated_o     = r_gated;
    assign all_gated_o = &r_gated;

`ifdef SYNTHESIS
    assign clk_o = {NUM_CH{clk_i}};
`else
    logic [NUM_CH-1:0] r_en_lat;

    // Low-transparent latch: enable can only change while clk_i is low, so no runt pulses.
    always_latch begin
        if (!clk_i) begin
            r_en_lat <= r_clk_en | {NUM_CH{scan_cg_en_i}};
        end
    end

    assign clk_o = {NUM_CH{clk_i}} & r_en_lat;
`endif

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Directed-vector bench for cv32e40p_clock_gate_ctrl (NUM_CH=4, IDLE=8, WAKE=2).
module tb_cv32e40p_clock_gate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       scan_cg_en_i;
    logic [3:0] force_on_i;
    logic [3:0] busy_i;
    logic [3:0] wake_req_i;
    logic [3:0] wake_ack_o;
    logic [3:0] clk_en_o;
    logic [3:0] gated_o;
    logic       all_gated_o;
    logic [3:0] clk_o;

    int n_checks = 0;
    int n_fail   = 0;

    cv32e40p_clock_gate_ctrl #(
        .NUM_CH      (4),
        .IDLE_CYCLES (8),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .scan_cg_en_i (scan_cg_en_i),
        .force_on_i   (force_on_i),
        .busy_i       (busy_i),
        .wake_req_i   (wake_req_i),
        .wake_ack_o   (wake_ack_o),
        .clk_en_o     (clk_en_o),
        .gated_o      (gated_o),
        .all_gated_o  (all_gated_o),
        .clk_o        (clk_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [3:0] force_on;
        logic [3:0] busy;
        logic [3:0] wake;
        int         n_edges;
        logic [3:0] exp_en;
        logic [3:0] exp_gated;
        logic [3:0] exp_ack;
    } vec_t;

    vec_t vecs[31];

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %h, expected %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int idx, input logic rst, input logic [3:0] frc, input logic [3:0] bsy,
                           input logic [3:0] wk, input int n, input logic [3:0] en,
                           input logic [3:0] gt, input logic [3:0] ack);
        vecs[idx].rst       = rst;
        vecs[idx].force_on  = frc;
        vecs[idx].busy      = bsy;
        vecs[idx].wake      = wk;
        vecs[idx].n_edges   = n;
        vecs[idx].exp_en    = en;
        vecs[idx].exp_gated = gt;
        vecs[idx].exp_ack   = ack;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            rst_i      = vecs[r].rst;
            force_on_i = vecs[r].force_on;
            busy_i     = vecs[r].busy;
            wake_req_i = vecs[r].wake;
            if (vecs[r].n_edges == 0) begin
                #1;
            end else begin
                repeat (vecs[r].n_edges) begin
                    @(posedge clk_i);
                    #1;
                end
            end
            check("clk_en_o", r, clk_en_o, vecs[r].exp_en);
            check("gated_o", r, gated_o, vecs[r].exp_gated);
            check("wake_ack_o", r, wake_ack_o, vecs[r].exp_ack);
            check("all_gated_o", r, {3'b000, all_gated_o}, {3'b000, vecs[r].exp_gated == 4'hF});
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        scan_cg_en_i = 1'b0;
        force_on_i   = '0;
        busy_i       = '0;
        wake_req_i   = '0;

        //          idx rst frc  bsy  wake  n    en   gated ack
        set_vec( 0, 1, 4'h0, 4'h0, 4'h0,   3, 4'hF, 4'h0, 4'h0);
        set_vec( 1, 0, 4'h0, 4'h0, 4'h0,   7, 4'hF, 4'h0, 4'h0);
        set_vec( 2, 0, 4'h0, 4'h0, 4'h0,   1, 4'h0, 4'hF, 4'h0);
        set_vec( 3, 0, 4'h0, 4'h0, 4'h4,   1, 4'h4, 4'hB, 4'h0);
        set_vec( 4, 0, 4'h0, 4'h0, 4'h4,   1, 4'h4, 4'hB, 4'h0);
        set_vec( 5, 0, 4'h0, 4'h0, 4'h4,   1, 4'h4, 4'hB, 4'h4);
        set_vec( 6, 0, 4'h0, 4'h0, 4'h0,   0, 4'h4, 4'hB, 4'h0);
        set_vec( 7, 0, 4'h0, 4'h0, 4'h0,   7, 4'h4, 4'hB, 4'h0);
        set_vec( 8, 0, 4'h0, 4'h0, 4'h0,   1, 4'h0, 4'hF, 4'h0);
        set_vec( 9, 1, 4'h0, 4'h0, 4'h0,   1, 4'hF, 4'h0, 4'h0);
        set_vec(10, 0, 4'h0, 4'h0, 4'h0,   4, 4'hF, 4'h0, 4'h0);
        set_vec(11, 0, 4'h0, 4'h1, 4'h0,   1, 4'hF, 4'h0, 4'h0);
        set_vec(12, 0, 4'h0, 4'h0, 4'h0,   2, 4'hF, 4'h0, 4'h0);
        set_vec(13, 0, 4'h0, 4'h0, 4'h0,   1, 4'h1, 4'hE, 4'h0);
        set_vec(14, 0, 4'h0, 4'h0, 4'h0,   4, 4'h1, 4'hE, 4'h0);
        set_vec(15, 0, 4'h0, 4'h0, 4'h0,   1, 4'h0, 4'hF, 4'h0);
        set_vec(16, 0, 4'h0, 4'h2, 4'h0,   1, 4'h2, 4'hD, 4'h0);
        set_vec(17, 0, 4'h0, 4'h0, 4'h0,   2, 4'h2, 4'hD, 4'h0);
        set_vec(18, 0, 4'h0, 4'h0, 4'h0,   7, 4'h2, 4'hD, 4'h0);
        set_vec(19, 0, 4'h0, 4'h0, 4'h0,   1, 4'h0, 4'hF, 4'h0);
        set_vec(20, 0, 4'h0, 4'h0, 4'h8,   1, 4'h8, 4'h7, 4'h0);
        set_vec(21, 1, 4'h0, 4'h0, 4'h8,   1, 4'hF, 4'h0, 4'h0);
        set_vec(22, 0, 4'h0, 4'h0, 4'h8,   0, 4'hF, 4'h0, 4'h8);
        set_vec(23, 0, 4'h0, 4'h0, 4'h0,   0, 4'hF, 4'h0, 4'h0);
        set_vec(24, 0, 4'h1, 4'h0, 4'h0, 100, 4'h1, 4'hE, 4'h0);
        set_vec(25, 0, 4'h0, 4'h0, 4'h0,   7, 4'h1, 4'hE, 4'h0);
        set_vec(26, 0, 4'h0, 4'h0, 4'h0,   1, 4'h0, 4'hF, 4'h0);
        set_vec(27, 0, 4'h2, 4'h0, 4'h0,   1, 4'h2, 4'hD, 4'h0);
        set_vec(28, 0, 4'h2, 4'h0, 4'h0,  20, 4'h2, 4'hD, 4'h0);
        set_vec(29, 0, 4'h0, 4'h0, 4'h0,   7, 4'h2, 4'hD, 4'h0);
        set_vec(30, 0, 4'h0, 4'h0, 4'h0,   1, 4'h0, 4'hF, 4'h0);

        run_rows(0, 8);

        // All channels gated: the pulse on the gating edge still passed, the next one must not.
        @(posedge clk_i);
        #1;
        check("clk_o flat when gated", 100, clk_o, 4'h0);

        // Scan enable opens the gates only from the next low phase, then holds through high.
        scan_cg_en_i = 1'b1;
        #1;
        check("clk_o scan held in high phase", 101, clk_o, 4'h0);
        @(negedge clk_i);
        #1;
        check("clk_o scan low phase", 102, clk_o, 4'h0);
        @(posedge clk_i);
        #1;
        check("clk_o scan pulse", 103, clk_o, 4'hF);
        check("gated_o under scan", 104, gated_o, 4'hF);
        check("clk_en_o under scan", 105, clk_en_o, 4'h0);
        scan_cg_en_i = 1'b0;
        #2;
        check("clk_o pulse not truncated", 106, clk_o, 4'hF);
        @(posedge clk_i);
        #1;
        check("clk_o after scan off", 107, clk_o, 4'h0);
        check("gated_o after scan", 108, gated_o, 4'hF);

        run_rows(9, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
